alu_sweep_sequencer: RTL and testbench
======================================

Name: alu_sweep_sequencer

Overview:
- Clocked stimulus/capture engine for the 16-bit combinational `alu` (inputs A, B, ALU_Sel; outputs ALU_Out, CarryOut).
- On `start`, it latches one operand pair and sweeps a run of consecutive op selects through the ALU.
- For each select it drives the ALU, waits a fixed settle time, and captures {CarryOut, ALU_Out} into an internal result buffer.
- Software or bench logic reads the buffer by index after `done`. It is the synthesizable replacement for the hand-written operand sweep used in unit bring-up.

Parameters:
- WIDTH, 16, operand/result width
- SEL_W, 4, op-select width; buffer depth is 2**SEL_W
- SETTLE_CYC, 2, cycles waited after driving before capture (legal range 0..15)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- start  in  1  sweep request; sampled only in IDLE
- a_in  in  WIDTH  operand A, latched on accepted start
- b_in  in  WIDTH  operand B, latched on accepted start
- first_sel  in  SEL_W  first op select of the sweep
- num_ops  in  SEL_W+1  number of ops to sweep, 0..2**SEL_W
- busy  out  1  high from the accepted start until done
- done  out  1  one-cycle pulse at sweep completion
- alu_a  out  WIDTH  to ALU A (registered)
- alu_b  out  WIDTH  to ALU B (registered)
- alu_sel  out  SEL_W  to ALU_Sel (registered)
- alu_out  in  WIDTH  from ALU_Out
- alu_carry  in  1  from CarryOut
- rd_idx  in  SEL_W  buffer read index (ALU select value)
- rd_data  out  WIDTH+1  {carry, result} at rd_idx, combinational read
- rd_valid  out  1  entry at rd_idx captured in the current/last sweep
- fail_cnt  out  SEL_W+1  mismatch count (see Optional Feature)

Behaviour:
- Reset (async, immediate):
  - FSM goes to IDLE.
  - busy, done, alu_a, alu_b, alu_sel, fail_cnt all become 0.
  - The valid bitmap clears to 0. Buffer data is don't-care.
- FSM states: IDLE, DRIVE, WAIT, CAPTURE, FINISH.
- IDLE, start=1:
  - Latch a_in/b_in into alu_a/alu_b; alu_sel<=first_sel; ops_left<=num_ops.
  - Clear the valid bitmap and fail_cnt; busy<=1.
  - Go to DRIVE, or to FINISH if num_ops==0.
- DRIVE: 1 cycle, ALU inputs stable. Next: WAIT if SETTLE_CYC>0, else CAPTURE. The wait counter loads SETTLE_CYC-1.
- WAIT: decrement the counter; go to CAPTURE when it reaches 0.
- CAPTURE:
  - buf[alu_sel] <= {alu_carry, alu_out}; valid[alu_sel]<=1; ops_left decrements.
  - If ops_left==1, go to FINISH. Otherwise alu_sel<=alu_sel+1 (wraps mod 2**SEL_W) and go to DRIVE.
- FINISH: done=1 for exactly one cycle; busy<=0; go to IDLE.
- Timing: each op takes SETTLE_CYC+2 cycles. done is high in cycle num_ops*(SETTLE_CYC+2)+1 counted from the start edge (edge = cycle 0). With num_ops==0, done is high in cycle 1.
- start while busy: ignored, no queuing. Operand inputs are only sampled at the accepted start.
- num_ops==2**SEL_W: all entries are written once and the sweep wraps past the top select.
- Buffer reads:
  - Reads are allowed at any time; rd_valid reflects the live bitmap, so a partial sweep is observable.
  - A read of the entry being captured in the same cycle returns the old value and rd_valid=0 until the next cycle.
- alu_a/alu_b/alu_sel hold their last values in IDLE.

Optional Feature:
- Macro: ALU_SWEEP_CHECK_EN.
- When defined:
  - In CAPTURE, if alu_sel is 0 (ADD) or 1 (SUB), compare the captured value against a built-in expected {carry, result}.
  - ADD expected = alu_a+alu_b, with carry = bit WIDTH of the sum.
  - SUB expected = alu_a-alu_b, with carry = borrow (1 when alu_a<alu_b).
  - On mismatch, fail_cnt increments, saturating at all-ones. Other selects are not checked.
- When undefined: fail_cnt is tied to 0 and no comparator logic exists.

Decomposition:
- Package alu_pkg:
  - ALU_W, ALU_SEL_W constants.
  - ALU_OP_ADD=4'h0, ALU_OP_SUB=4'h1 localparams.
  - sweep_state_t enum.
  - alu_result_t packed struct {carry, value}.
- One sub-module, alu_result_buf: 2**SEL_W x (WIDTH+1) register file with valid bitmap, single write port, combinational read port, synchronous bitmap clear.

Test Plan:
- Reset mid-sweep: assert rst during WAIT of op 1 -> busy=0, done=0, alu_sel=0, all rd_valid=0 immediately. A following start works normally.
- Basic sweep: a_in=16'h00FA, b_in=16'h0002, first_sel=0, num_ops=2, SETTLE_CYC=2, reference ALU model attached -> done in cycle 9. rd_idx=0 gives 17'h000FC; rd_idx=1 gives 17'h000F8. With ALU_SWEEP_CHECK_EN, fail_cnt=0.
- Wrap: first_sel=4'hE, num_ops=3 -> selects driven E, F, 0. Valid bitmap = bits 14, 15, 0 only.
- Zero-length and busy-ignore: num_ops=0 -> done in cycle 1, no rd_valid set. A start pulse asserted while busy changes neither operands nor timing.
- Carry/borrow: A=16'hFFFF, B=16'h0001 -> ADD entry 17'h10000. A=16'h0001, B=16'h0002 -> SUB entry 17'h1FFFF.
- Checker (ALU_SWEEP_CHECK_EN): bench corrupts alu_out bit 0 on the SUB cycle -> fail_cnt=1 after done. 20 sweeps all corrupted -> fail_cnt saturates at 31 (cleared at each start, so 2 per sweep max; check saturation by forcing the counter).

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU sweep sequencer and its result buffer.
package alu_pkg;

    localparam int ALU_W     = 16;
    localparam int ALU_SEL_W = 4;

    localparam logic [3:0] ALU_OP_ADD = 4'h0;
    localparam logic [3:0] ALU_OP_SUB = 4'h1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DRIVE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_FINISH  = 3'd4
    } sweep_state_t;

    typedef struct packed {
        logic             carry;
        logic [ALU_W-1:0] value;
    } alu_result_t;

endpackage

// File: rtl/alu_result_buf.sv
// Result register file indexed by ALU select, with a live valid bitmap.
// Single write port, combinational read port, synchronous bitmap clear.
import alu_pkg::*;

module alu_result_buf #(
    parameter int WIDTH = ALU_W,
    parameter int SEL_W = ALU_SEL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [SEL_W-1:0] wr_idx,
    input  logic [WIDTH:0]   wr_data,
    input  logic [SEL_W-1:0] rd_idx,
    output logic [WIDTH:0]   rd_data,
    output logic             rd_valid
);

    localparam int DEPTH = 2 ** SEL_W;

    logic [WIDTH:0]   mem_r [DEPTH];
    logic [DEPTH-1:0] valid_r;

    // Data storage: contents are don't-care until the valid bit says otherwise.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_idx] <= wr_data;
        end
    end

    // Valid bitmap: async reset, cleared at sweep start, set per captured entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= {DEPTH{1'b0}};
        end else if (clr) begin
            valid_r <= {DEPTH{1'b0}};
        end else if (wr_en) begin
            valid_r[wr_idx] <= 1'b1;
        end
    end

    assign rd_data  = mem_r[rd_idx];
    assign rd_valid = valid_r[rd_idx];

endmodule

// File: rtl/alu_sweep_sequencer.sv
// Drives one operand pair through a run of ALU selects and captures each result.
// Optional self-check of ADD/SUB results is enabled by defining ALU_SWEEP_CHECK_EN.
import alu_pkg::*;

module alu_sweep_sequencer #(
    parameter int WIDTH      = ALU_W,
    parameter int SEL_W      = ALU_SEL_W,
    parameter int SETTLE_CYC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [SEL_W-1:0] first_sel,
    input  logic [SEL_W:0]   num_ops,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [SEL_W-1:0] alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_carry,
    input  logic [SEL_W-1:0] rd_idx,
    output logic [WIDTH:0]   rd_data,
    output logic             rd_valid,
    output logic [SEL_W:0]   fail_cnt
);

    localparam logic [3:0]   SETTLE_LOAD_C = (SETTLE_CYC > 0) ? 4'(SETTLE_CYC - 1) : 4'd0;
    localparam logic [SEL_W:0] ONE_OP_C    = (SEL_W + 1)'(1);
    localparam logic [SEL_W:0] NO_OPS_C    = (SEL_W + 1)'(0);

    sweep_state_t     state_r;
    sweep_state_t     next_state_s;
    logic [3:0]       wait_cnt_r;
    logic [SEL_W:0]   ops_left_r;
    logic [WIDTH-1:0] alu_a_r;
    logic [WIDTH-1:0] alu_b_r;
    logic [SEL_W-1:0] alu_sel_r;
    logic             busy_r;
    logic             done_r;
    logic             accept_s;
    logic             capture_s;
    logic [WIDTH:0]   captured_s;

    assign accept_s   = (state_r == ST_IDLE) && start;
    assign capture_s  = (state_r == ST_CAPTURE);
    assign captured_s = {alu_carry, alu_out};

    // Next-state decode for the sweep FSM.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_state_s = (num_ops == NO_OPS_C) ? ST_FINISH : ST_DRIVE;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                if (SETTLE_CYC > 0) begin
                    next_state_s = ST_WAIT;
                end else begin
                    next_state_s = ST_CAPTURE;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_r == 4'd0) begin
                    next_state_s = ST_CAPTURE;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_CAPTURE: begin
                if (ops_left_r == ONE_OP_C) begin
                    next_state_s = ST_FINISH;
                end else begin
                    next_state_s = ST_DRIVE;
                end
            end
            ST_FINISH: next_state_s = ST_IDLE;
            default:   next_state_s = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Registered ALU drive, op bookkeeping and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a_r    <= {WIDTH{1'b0}};
            alu_b_r    <= {WIDTH{1'b0}};
            alu_sel_r  <= {SEL_W{1'b0}};
            ops_left_r <= NO_OPS_C;
            wait_cnt_r <= 4'd0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        alu_a_r    <= a_in;
                        alu_b_r    <= b_in;
                        alu_sel_r  <= first_sel;
                        ops_left_r <= num_ops;
                        busy_r     <= 1'b1;
                    end
                end
                ST_DRIVE: wait_cnt_r <= SETTLE_LOAD_C;
                ST_WAIT: begin
                    if (wait_cnt_r != 4'd0) begin
                        wait_cnt_r <= wait_cnt_r - 4'd1;
                    end
                end
                ST_CAPTURE: begin
                    ops_left_r <= ops_left_r - ONE_OP_C;
                    // The last op leaves alu_sel on the final select driven.
                    if (ops_left_r != ONE_OP_C) begin
                        alu_sel_r <= alu_sel_r + SEL_W'(1);
                    end
                end
                ST_FINISH: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                end
                default: busy_r <= 1'b0;
            endcase
        end
    end

    alu_result_buf #(
        .WIDTH (WIDTH),
        .SEL_W (SEL_W)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .clr      (accept_s),
        .wr_en    (capture_s),
        .wr_idx   (alu_sel_r),
        .wr_data  (captured_s),
        .rd_idx   (rd_idx),
        .rd_data  (rd_data),
        .rd_valid (rd_valid)
    );

`ifdef ALU_SWEEP_CHECK_EN
    logic [WIDTH:0] expect_s;
    logic           check_s;
    logic [SEL_W:0] fail_cnt_r;

    // Reference ADD/SUB result; carry is bit WIDTH, which is the borrow for SUB.
    always_comb begin
        expect_s = {(WIDTH + 1){1'b0}};
        check_s  = 1'b0;
        if (alu_sel_r == SEL_W'(ALU_OP_ADD)) begin
            expect_s = {1'b0, alu_a_r} + {1'b0, alu_b_r};
            check_s  = 1'b1;
        end else if (alu_sel_r == SEL_W'(ALU_OP_SUB)) begin
            expect_s = {1'b0, alu_a_r} - {1'b0, alu_b_r};
            check_s  = 1'b1;
        end else begin
            check_s  = 1'b0;
        end
    end

    // Saturating mismatch counter, cleared on each accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_cnt_r <= NO_OPS_C;
        end else if (accept_s) begin
            fail_cnt_r <= NO_OPS_C;
        end else if (capture_s && check_s && (captured_s != expect_s)
                     && (fail_cnt_r != {(SEL_W + 1){1'b1}})) begin
            fail_cnt_r <= fail_cnt_r + ONE_OP_C;
        end
    end

    assign fail_cnt = fail_cnt_r;
`else
    assign fail_cnt = {(SEL_W + 1){1'b0}};
`endif

    assign alu_a   = alu_a_r;
    assign alu_b   = alu_b_r;
    assign alu_sel = alu_sel_r;
    assign busy    = busy_r;
    assign done    = done_r;

endmodule

// File: tb/tb_alu_sweep_sequencer.sv
// Self-checking bench for alu_sweep_sequencer: vector table plus scoreboard of captured entries.
module tb_alu_sweep_sequencer;
    import alu_pkg::*;

    localparam int W  = 16;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  a_in, b_in;
    logic [SW-1:0] first_sel;
    logic [SW:0]   num_ops;
    logic          busy, done;
    logic [W-1:0]  alu_a, alu_b, alu_out;
    logic [SW-1:0] alu_sel, rd_idx;
    logic          alu_carry;
    logic [W:0]    rd_data;
    logic          rd_valid;
    logic [SW:0]   fail_cnt;
    logic          corrupt_en;
    logic [W:0]    alu_res;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [SW-1:0] fs;
        logic [SW:0]   n;
        int            glitch;
        int            exp_done;
        logic [15:0]   exp_valid;
        logic [SW-1:0] h0_idx;
        logic [W:0]    h0_val;
        logic [SW-1:0] h1_idx;
        logic [W:0]    h1_val;
        logic [1:0]    h_en;
        logic          corrupt;
    } vec_t;

    typedef struct {
        logic [SW-1:0] idx;
        logic [W:0]    data;
    } sb_t;

    vec_t vecs[8];
    sb_t  sb_q[$];

    alu_sweep_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
        .first_sel(first_sel), .num_ops(num_ops), .busy(busy), .done(done),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
        .alu_carry(alu_carry), .rd_idx(rd_idx), .rd_data(rd_data),
        .rd_valid(rd_valid), .fail_cnt(fail_cnt)
    );

    always #5 clk = ~clk;

    // Reference 16-op ALU; optional corruption flips bit 0 of the SUB result.
    function automatic logic [W:0] ref_alu(input logic [SW-1:0] sel, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic corrupt);
        logic [W:0] r;
        r = '0;
        case (sel)
            4'h0: r = {1'b0, a} + {1'b0, b};
            4'h1: r = {1'b0, a} - {1'b0, b};
            4'h2: r = {1'b0, a * b};
            4'h3: r = {1'b0, a & ~b};
            4'h4: r = {1'b0, a << 1};
            4'h5: r = {1'b0, a >> 1};
            4'h6: r = {1'b0, a[W-2:0], a[W-1]};
            4'h7: r = {1'b0, a[0], a[W-1:1]};
            4'h8: r = {1'b0, a & b};
            4'h9: r = {1'b0, a | b};
            4'hA: r = {1'b0, a ^ b};
            4'hB: r = {1'b0, ~(a | b)};
            4'hC: r = {1'b0, ~(a & b)};
            4'hD: r = {1'b0, ~(a ^ b)};
            4'hE: r = (a > b) ? 17'h00001 : 17'h00000;
            default: r = (a == b) ? 17'h00001 : 17'h00000;
        endcase
        if (corrupt && sel == 4'h1) r[0] = ~r[0];
        return r;
    endfunction

    always_comb alu_res = ref_alu(alu_sel, alu_a, alu_b, corrupt_en);
    assign {alu_carry, alu_out} = alu_res;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic read_entry(input logic [SW-1:0] idx, output logic [W:0] d, output logic v);
        rd_idx = idx;
        #1;
        d = rd_data;
        v = rd_valid;
    endtask

    task automatic read_bitmap(output logic [15:0] vb);
        logic [W:0] d;
        for (int i = 0; i < 16; i++) read_entry(SW'(i), d, vb[i]);
    endtask

    task automatic run_vec(input vec_t v, input logic [SW:0] exp_fail);
        int          cyc;
        logic [W:0]  d;
        logic        vl;
        logic [15:0] vb;
        sb_t         e;
        corrupt_en = v.corrupt;
        for (int k = 0; k < int'(v.n); k++) begin
            e.idx  = v.fs + SW'(k);
            e.data = ref_alu(e.idx, v.a, v.b, v.corrupt);
            sb_q.push_back(e);
        end
        @(negedge clk);
        a_in = v.a; b_in = v.b; first_sel = v.fs; num_ops = v.n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        check("busy_at_start", 32'(busy), 32'd1);
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (cyc == v.glitch) begin
                start = 1'b1; a_in = 16'hDEAD; b_in = 16'hBEEF; first_sel = 4'h7; num_ops = 5'd9;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check("done_cycle", 32'(cyc), 32'(v.exp_done));
        check("busy_at_done", 32'(busy), 32'd0);
        @(negedge clk);
        check("done_pulse_width", 32'(done), 32'd0);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            read_entry(e.idx, d, vl);
            check("sb_entry_data", 32'(d), 32'(e.data));
            check("sb_entry_valid", 32'(vl), 32'd1);
        end
        if (v.h_en[0]) begin
            read_entry(v.h0_idx, d, vl);
            check("hand_entry0", 32'(d), 32'(v.h0_val));
        end
        if (v.h_en[1]) begin
            read_entry(v.h1_idx, d, vl);
            check("hand_entry1", 32'(d), 32'(v.h1_val));
        end
        read_bitmap(vb);
        check("valid_bitmap", 32'(vb), 32'(v.exp_valid));
        check("fail_cnt", 32'(fail_cnt), 32'(exp_fail));
        corrupt_en = 1'b0;
    endtask

    initial begin
        logic [15:0] vb;
        logic [W:0]  d;
        logic        vl;
        logic [SW:0] corrupt_fail;
`ifdef ALU_SWEEP_CHECK_EN
        corrupt_fail = 5'd1;
`else
        corrupt_fail = 5'd0;
`endif
        //          a         b         fs    n      gl  done valid     h0 idx/val       h1 idx/val       en     corrupt
        vecs[0] = '{16'h00FA, 16'h0002, 4'h0, 5'd2,  -1,  9, 16'h0003, 4'h0, 17'h000FC, 4'h1, 17'h000F8, 2'b11, 1'b0};
        vecs[1] = '{16'h1234, 16'h0F0F, 4'hE, 5'd3,  -1, 13, 16'hC001, 4'hE, 17'h00001, 4'h0, 17'h02143, 2'b11, 1'b0};
        vecs[2] = '{16'h5555, 16'h3333, 4'h3, 5'd0,  -1,  1, 16'h0000, 4'h0, 17'h00000, 4'h0, 17'h00000, 2'b00, 1'b0};
        vecs[3] = '{16'hFFFF, 16'h0001, 4'h0, 5'd1,  -1,  5, 16'h0001, 4'h0, 17'h10000, 4'h0, 17'h00000, 2'b01, 1'b0};
        vecs[4] = '{16'h0001, 16'h0002, 4'h1, 5'd1,  -1,  5, 16'h0002, 4'h1, 17'h1FFFF, 4'h0, 17'h00000, 2'b01, 1'b0};
        vecs[5] = '{16'hA5C3, 16'h0007, 4'h5, 5'd16, -1, 65, 16'hFFFF, 4'h8, 17'h00003, 4'h1, 17'h0A5BC, 2'b11, 1'b0};
        vecs[6] = '{16'h0100, 16'h0001, 4'h0, 5'd2,   3,  9, 16'h0003, 4'h0, 17'h00101, 4'h1, 17'h000FF, 2'b11, 1'b0};
        vecs[7] = '{16'h00FA, 16'h0002, 4'h0, 5'd2,  -1,  9, 16'h0003, 4'h1, 17'h000F9, 4'h0, 17'h000FC, 2'b11, 1'b1};

        rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; first_sel = '0; num_ops = '0;
        rd_idx = '0; corrupt_en = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        check("rst_alu_b", 32'(alu_b), 32'd0);
        check("rst_alu_sel", 32'(alu_sel), 32'd0);
        check("rst_fail_cnt", 32'(fail_cnt), 32'd0);
        read_bitmap(vb);
        check("rst_bitmap", 32'(vb), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], (i == 7) ? corrupt_fail : 5'd0);

        // Reset during the settle wait of op 1, then confirm a clean restart.
        @(negedge clk);
        a_in = 16'h00FA; b_in = 16'h0002; first_sel = 4'h0; num_ops = 5'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        read_entry(4'h0, d, vl);
        check("partial_valid0", 32'(vl), 32'd1);
        read_entry(4'h1, d, vl);
        check("partial_valid1", 32'(vl), 32'd0);
        check("partial_alu_sel", 32'(alu_sel), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_alu_sel", 32'(alu_sel), 32'd0);
        read_bitmap(vb);
        check("midrst_bitmap", 32'(vb), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_vec(vecs[0], 5'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
